f_le_responder: RTL



---
 rtl/f_le_pkg.sv | 32 +++
 rtl/f_le_classify.sv | 29 ++
 rtl/f_le_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/f_le_pkg.sv
// Shared types, sizing and field helpers for the chunked FP64 less-or-equal responder.
package f_le_pkg;

    localparam int FLEN    = 64;
    localparam int EXP_W   = 11;
    localparam int CHUNK_W = 16;
    localparam int MANT_W  = FLEN - 1 - EXP_W;
    localparam int MAG_W   = FLEN - 1;
    localparam int NCHUNK  = (MAG_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W   = NCHUNK * CHUNK_W;
    localparam int CNT_W   = $clog2(NCHUNK) + 1;

    typedef enum logic [1:0] {IDLE, CLASSIFY, MAG, RESP} state_e;

    function automatic logic is_nan(input logic [FLEN-1:0] x);
        return (&x[FLEN-2:MANT_W]) && (|x[MANT_W-1:0]);
    endfunction

    function automatic logic is_zero(input logic [FLEN-1:0] x);
        return ~|x[FLEN-2:0];
    endfunction

    // Magnitude {exp,mant} is left-aligned in PAD_W bits; chunk 0 is the most significant.
    function automatic logic [CHUNK_W-1:0] mag_chunk(input logic [FLEN-1:0] x,
                                                     input logic [CNT_W-1:0] i);
        logic [PAD_W-1:0] m;
        m = PAD_W'(x[FLEN-2:0]) << (PAD_W - MAG_W);
        m = m >> (CHUNK_W * (NCHUNK - 1 - int'(i)));
        return m[CHUNK_W-1:0];
    endfunction

endpackage

// File: rtl/f_le_classify.sv
// Single-cycle pre-decision: NaN, both-zero and sign mismatch settle the compare without a magnitude scan.
module f_le_classify
    import f_le_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            decided,
    output logic            res,
    output logic            err
);

    always_comb begin
        decided = 1'b0;
        res     = 1'b0;
        err     = 1'b0;
        if (is_nan(a) || is_nan(b)) begin
            decided = 1'b1;
            err     = 1'b1;
        end else if (is_zero(a) && is_zero(b)) begin
            decided = 1'b1;
            res     = 1'b1;
        end else if (a[FLEN-1] != b[FLEN-1]) begin
            // a negative and b positive is the only mismatch where a <= b
            decided = 1'b1;
            res     = a[FLEN-1];
        end
    end

endmodule

// File: rtl/f_le_responder.sv
// Multi-cycle chunked FP compare (a <= b) behind valid/ready; widths come from f_le_pkg.
// F_LE_EARLY_EXIT_EN: respond as soon as decided; otherwise every response takes NCHUNK+2 cycles.
module f_le_responder
    import f_le_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [FLEN-1:0] req_a,
    input  logic [FLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_res,
    output logic            rsp_err,
    output logic            busy
);

    state_e             state_q, state_d;
    logic [FLEN-1:0]    a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_q, res_d, err_q, err_d, done_q, done_d;

    logic               cls_decided, cls_res, cls_err;
    logic [CHUNK_W-1:0] ca, cb;
    logic               chunk_ne, chunk_res, last;

    f_le_classify u_classify (
        .a       (a_q),
        .b       (b_q),
        .decided (cls_decided),
        .res     (cls_res),
        .err     (cls_err)
    );

    assign ca        = mag_chunk(a_q, cnt_q);
    assign cb        = mag_chunk(b_q, cnt_q);
    assign chunk_ne  = (ca != cb);
    // Signs are equal in MAG; for negatives the larger magnitude is the smaller value
    assign chunk_res = (ca < cb) ^ a_q[FLEN-1];
    assign last      = (cnt_q == CNT_W'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                res_d  = cls_res;
                err_d  = cls_err;
                done_d = cls_decided;
                cnt_d  = '0;
`ifdef F_LE_EARLY_EXIT_EN
                state_d = cls_decided ? RESP : MAG;
`else
                state_d = MAG;
`endif
            end
            MAG: begin
                // Only the first decision counts when the scan keeps going
                if (!done_q && chunk_ne) begin
                    res_d  = chunk_res;
                    done_d = 1'b1;
                end else if (!done_q && last) begin
                    res_d  = 1'b1;
                    done_d = 1'b1;
                end
`ifdef F_LE_EARLY_EXIT_EN
                if (chunk_ne || last) state_d = RESP;
                else                  cnt_d   = cnt_q + 1'b1;
`else
                if (last) state_d = RESP;
                else      cnt_d   = cnt_q + 1'b1;
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_res   = (state_q == RESP) && res_q;
        rsp_err   = (state_q == RESP) && err_q;
        busy      = (state_q != IDLE);
    end

endmodule
